// File: rtl/sfm_pkg.sv
// Shared types and helpers for the softmax accelerator TCDM responder.
package sfm_pkg;

    localparam int unsigned SFM_DATA_WIDTH = 128;
    localparam int unsigned SFM_ADDR_WIDTH = 32;

    typedef struct packed {
        logic [SFM_ADDR_WIDTH-1:0]   add;
        logic                        wen;
        logic [SFM_DATA_WIDTH/8-1:0] be;
        logic [SFM_DATA_WIDTH-1:0]   data;
    } tcdm_req_t;

    typedef struct packed {
        logic [SFM_DATA_WIDTH-1:0] r_data;
    } tcdm_resp_t;

    // Access counters stick at all-ones instead of wrapping.
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

endpackage

// File: rtl/sfm_tcdm_responder_if.sv
// TCDM request/response bus between the streamer (master) and a memory responder (slave).
// Handshake: a request transfers on a cycle with req & gnt; a response transfers on a cycle
// with r_valid & r_ready, and r_data is held stable while r_valid is high and r_ready is low.
interface sfm_tcdm_responder_if #(
    parameter int unsigned DATA_WIDTH = 128,
    parameter int unsigned ADDR_WIDTH = 32
);
    logic                      req;
    logic                      gnt;
    logic [ADDR_WIDTH-1:0]     add;
    logic                      wen;
    logic [DATA_WIDTH/8-1:0]   be;
    logic [DATA_WIDTH-1:0]     data;
    logic [DATA_WIDTH-1:0]     r_data;
    logic                      r_valid;
    logic                      r_ready;

    modport master (
        output req, add, wen, be, data, r_ready,
        input  gnt, r_data, r_valid
    );

    modport slave (
        input  req, add, wen, be, data, r_ready,
        output gnt, r_data, r_valid
    );

endinterface

// File: rtl/sfm_tcdm_resp_fifo.sv
// First-word-fall-through buffer for read responses; head is visible whenever count_o != 0.
module sfm_tcdm_resp_fifo #(
    parameter  int unsigned DATA_WIDTH = 128,
    parameter  int unsigned DEPTH      = 2,
    localparam int unsigned CW         = $clog2(DEPTH + 1)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  push_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  pop_i,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic [CW-1:0]         count_o
);
    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    logic [DATA_WIDTH-1:0] buf_q [DEPTH];
    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [CW-1:0]         count_q, count_d;

    // Pointers wrap explicitly so non-power-of-two depths work.
    function automatic logic [PW-1:0] ptr_next(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        count_d  = count_q;
        if (push_i) begin
            wr_ptr_d = ptr_next(wr_ptr_q);
        end
        if (pop_i) begin
            rd_ptr_d = ptr_next(rd_ptr_q);
        end
        if (push_i && !pop_i) begin
            count_d = count_q + CW'(1);
        end else if (!push_i && pop_i) begin
            count_d = count_q - CW'(1);
        end
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (push_i) begin
            buf_q[wr_ptr_q] <= data_i;
        end
    end

    assign data_o  = buf_q[rd_ptr_q];
    assign count_o = count_q;

endmodule

// File: rtl/sfm_tcdm_responder.sv
// Single-bank TCDM word memory answering req/gnt requests, with read data returned through a
// small response buffer, a grant stall input and saturating access counters.
module sfm_tcdm_responder
    import sfm_pkg::*;
#(
    parameter int unsigned DATA_WIDTH = SFM_DATA_WIDTH,
    parameter int unsigned ADDR_WIDTH = SFM_ADDR_WIDTH,
    parameter int unsigned N_WORDS    = 1024,
    parameter int unsigned RESP_DEPTH = 2
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    req_i,
    output logic                    gnt_o,
    input  logic [ADDR_WIDTH-1:0]   add_i,
    input  logic                    wen_i,
    input  logic [DATA_WIDTH/8-1:0] be_i,
    input  logic [DATA_WIDTH-1:0]   data_i,
    output logic [DATA_WIDTH-1:0]   r_data_o,
    output logic                    r_valid_o,
    input  logic                    r_ready_i,
    input  logic                    stall_i,
    output logic [31:0]             n_reads_o,
    output logic [31:0]             n_writes_o
);
    localparam int unsigned BW  = DATA_WIDTH / 8;
    localparam int unsigned LSB = $clog2(BW);
    localparam int unsigned IW  = $clog2(N_WORDS);
    localparam int unsigned CW  = $clog2(RESP_DEPTH + 1);

    logic [DATA_WIDTH-1:0] mem [N_WORDS];

    logic [IW-1:0]         idx;
    logic                  addr_unused;
    logic                  rd_pend_q, rd_pend_d;
    logic [DATA_WIDTH-1:0] rd_data_q;
    logic [31:0]           n_reads_q, n_reads_d;
    logic [31:0]           n_writes_q, n_writes_d;

    logic [CW-1:0]         fifo_count;
    logic [DATA_WIDTH-1:0] fifo_head;
    logic                  fifo_empty;
    logic                  fifo_push;
    logic                  fifo_pop;
    logic                  bypass;
    logic                  pop;
    logic [CW:0]           occ;
    logic                  occ_next_free;
    logic                  wr_gnt;
    logic                  rd_gnt;

    // Byte offset and bits above the array depth are don't-care: addresses wrap.
    assign idx         = add_i[LSB +: IW];
    assign addr_unused = ^add_i;

    assign fifo_empty = (fifo_count == '0);
    assign r_valid_o  = !fifo_empty || rd_pend_q;
    assign r_data_o   = !fifo_empty ? fifo_head : (rd_pend_q ? rd_data_q : '0);
    assign pop        = r_valid_o && r_ready_i;

    // A read in flight counts against capacity until it is consumed.
    assign occ           = {1'b0, fifo_count} + {{CW{1'b0}}, rd_pend_q};
    assign occ_next_free = (occ < (CW+1)'(RESP_DEPTH)) || pop;

    assign gnt_o  = req_i && !stall_i && !rst_i && (!wen_i || occ_next_free);
    assign wr_gnt = gnt_o && !wen_i;
    assign rd_gnt = gnt_o && wen_i;

    // The in-flight word is presented directly when the buffer is empty; it is only
    // stored if the consumer did not take it this cycle.
    assign bypass    = rd_pend_q && fifo_empty && r_ready_i;
    assign fifo_push = rd_pend_q && !bypass;
    assign fifo_pop  = !fifo_empty && pop;

    sfm_tcdm_resp_fifo #(
        .DATA_WIDTH (DATA_WIDTH),
        .DEPTH      (RESP_DEPTH)
    ) u_resp_fifo (
        .clk_i   (clk_i),
        .rst_i   (rst_i),
        .push_i  (fifo_push),
        .data_i  (rd_data_q),
        .pop_i   (fifo_pop),
        .data_o  (fifo_head),
        .count_o (fifo_count)
    );

    always_comb begin
        rd_pend_d  = rd_gnt;
        n_reads_d  = rd_gnt ? sat_inc(n_reads_q) : n_reads_q;
        n_writes_d = wr_gnt ? sat_inc(n_writes_q) : n_writes_q;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_pend_q  <= 1'b0;
            n_reads_q  <= '0;
            n_writes_q <= '0;
        end else begin
            rd_pend_q  <= rd_pend_d;
            n_reads_q  <= n_reads_d;
            n_writes_q <= n_writes_d;
        end
    end

    always_ff @(posedge clk_i) begin
        if (wr_gnt) begin
            for (int b = 0; b < int'(BW); b++) begin
                if (be_i[b]) begin
                    mem[idx][b*8 +: 8] <= data_i[b*8 +: 8];
                end
            end
        end
        if (rd_gnt) begin
            rd_data_q <= mem[idx];
        end
    end

    assign n_reads_o  = n_reads_q;
    assign n_writes_o = n_writes_q;

endmodule

// File: tb/tb_sfm_tcdm_responder.sv
// Bench for sfm_tcdm_responder: directed scenarios plus random traffic against a word-level model.
module tb_sfm_tcdm_responder;
    localparam int DW = 128;
    localparam int AW = 32;
    localparam int BW = DW / 8;
    localparam int NW = 1024;
    localparam int RD = 2;

    logic          clk;
    logic          rst;
    logic          stall;
    logic [31:0]   n_reads;
    logic [31:0]   n_writes;

    sfm_tcdm_responder_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) bus ();

    sfm_tcdm_responder #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .N_WORDS    (NW),
        .RESP_DEPTH (RD)
    ) dut (
        .clk_i      (clk),
        .rst_i      (rst),
        .req_i      (bus.req),
        .gnt_o      (bus.gnt),
        .add_i      (bus.add),
        .wen_i      (bus.wen),
        .be_i       (bus.be),
        .data_i     (bus.data),
        .r_data_o   (bus.r_data),
        .r_valid_o  (bus.r_valid),
        .r_ready_i  (bus.r_ready),
        .stall_i    (stall),
        .n_reads_o  (n_reads),
        .n_writes_o (n_writes)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic [DW-1:0] act, input logic [DW-1:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, act, exp);
        end
    endtask

    // reference model: word array, outstanding-response queue, access counts
    logic [DW-1:0] mm [NW];
    logic [DW-1:0] exp_q [$];
    logic [31:0]   m_reads = 0;
    logic [31:0]   m_writes = 0;
    bit            armed = 0;

    always @(negedge clk) begin
        bit  pop;
        bit  eg;
        int  widx;
        if (rst) begin
            chk("rst_gnt", {127'b0, bus.gnt}, '0);
            exp_q.delete();
            m_reads  = 0;
            m_writes = 0;
            armed    = 1;
        end else if (armed) begin
            pop = (exp_q.size() > 0) && bus.r_ready;
            eg  = bus.req && !stall && (!bus.wen || exp_q.size() < RD || pop);
            chk("gnt", {127'b0, bus.gnt}, {127'b0, eg});
            chk("r_valid", {127'b0, bus.r_valid}, {127'b0, exp_q.size() > 0});
            if (exp_q.size() > 0) chk("r_data", bus.r_data, exp_q[0]);
            chk("n_reads", {96'b0, n_reads}, {96'b0, m_reads});
            chk("n_writes", {96'b0, n_writes}, {96'b0, m_writes});
            if (pop) void'(exp_q.pop_front());
            if (eg) begin
                widx = int'((bus.add / BW) % NW);
                if (bus.wen) begin
                    exp_q.push_back(mm[widx]);
                    if (m_reads != 32'hFFFF_FFFF) m_reads++;
                end else begin
                    for (int b = 0; b < BW; b++)
                        if (bus.be[b]) mm[widx][b*8 +: 8] = bus.data[b*8 +: 8];
                    if (m_writes != 32'hFFFF_FFFF) m_writes++;
                end
            end
        end
    end

    // driver
    task automatic drv(input logic r, input logic q, input logic w, input logic [AW-1:0] a,
                       input logic [BW-1:0] be, input logic [DW-1:0] d,
                       input logic st, input logic rdy);
        @(posedge clk);
        #1;
        rst         = r;
        bus.req     = q;
        bus.wen     = w;
        bus.add     = a;
        bus.be      = be;
        bus.data    = d;
        stall       = st;
        bus.r_ready = rdy;
    endtask

    task automatic idle(input logic rdy);
        drv(0, 0, 0, '0, '0, '0, 0, rdy);
    endtask

    function automatic logic [DW-1:0] rnd_word();
        return {$urandom, $urandom, $urandom, $urandom};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not complete in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [DW-1:0] w4;
        logic [DW-1:0] tmp;
        int            issued;
        logic [AW-1:0] a;

        rst = 1; stall = 0;
        bus.req = 0; bus.wen = 0; bus.add = '0; bus.be = '0; bus.data = '0; bus.r_ready = 0;
        repeat (3) @(posedge clk);

        idle(1);
        @(negedge clk);
        chk("rst_rdata", bus.r_data, '0);
        chk("rst_rvalid", {127'b0, bus.r_valid}, '0);

        // write then read
        drv(0, 1, 0, 32'h40, '1, {16{8'h11}}, 0, 1);
        drv(0, 1, 1, 32'h40, '0, '0, 0, 1);
        @(negedge clk);
        chk("t1_gnt", {127'b0, bus.gnt}, 128'd1);
        chk("t1_lat0", {127'b0, bus.r_valid}, '0);
        idle(1);
        @(negedge clk);
        chk("t1_valid", {127'b0, bus.r_valid}, 128'd1);
        chk("t1_data", bus.r_data, {16{8'h11}});
        chk("t1_nw", {96'b0, n_writes}, 128'd1);
        chk("t1_nr", {96'b0, n_reads}, 128'd1);

        // partial strobe
        drv(0, 1, 0, 32'h0, '1, {16{8'hFF}}, 0, 1);
        drv(0, 1, 0, 32'h0, 16'h000F, '0, 0, 1);
        drv(0, 1, 1, 32'h0, '0, '0, 0, 1);
        idle(1);
        @(negedge clk);
        chk("t2_data", bus.r_data, {{12{8'hFF}}, 32'h0});

        // back-pressure with a full response buffer
        for (int i = 0; i < 4; i++) begin
            tmp = rnd_word();
            if (i == 0) w4 = tmp;
            drv(0, 1, 0, AW'(32'h40 + i * 16), '1, tmp, 0, 1);
        end
        idle(1);
        issued = 0;
        for (int c = 0; c < 4; c++) begin
            drv(0, 1, 1, AW'(32'h40 + issued * 16), '0, '0, 0, 0);
            @(negedge clk);
            chk("t3_gnt", {127'b0, bus.gnt}, {127'b0, c < 2});
            if (bus.gnt) issued++;
        end
        for (int c = 0; c < 6 && issued < 4; c++) begin
            drv(0, 1, 1, AW'(32'h40 + issued * 16), '0, '0, 0, 1);
            @(negedge clk);
            chk("t3_rel_gnt", {127'b0, bus.gnt}, 128'd1);
            if (bus.gnt) issued++;
        end
        repeat (4) idle(1);

        // wrap-around with ignored low address bits
        drv(0, 1, 0, AW'(NW * BW + 32'h13), '1, {16{8'hA5}}, 0, 1);
        drv(0, 1, 1, 32'h10, '0, '0, 0, 1);
        idle(1);
        @(negedge clk);
        chk("t4_data", bus.r_data, {16{8'hA5}});

        // stall while responses drain
        drv(0, 1, 1, 32'h40, '0, '0, 0, 0);
        drv(0, 1, 1, 32'h50, '0, '0, 0, 0);
        for (int c = 0; c < 10; c++) begin
            drv(0, 1, 1'($urandom_range(0, 1)), 32'h60, '1, rnd_word(), 1, 1);
            @(negedge clk);
            chk("t5_gnt", {127'b0, bus.gnt}, '0);
        end
        chk("t5_drained", {127'b0, bus.r_valid}, '0);

        // reset one cycle after a read grant
        drv(0, 1, 1, 32'h50, '0, '0, 0, 1);
        drv(1, 0, 0, '0, '0, '0, 0, 1);
        idle(1);
        @(negedge clk);
        chk("t6_valid", {127'b0, bus.r_valid}, '0);
        chk("t6_nr", {96'b0, n_reads}, '0);
        chk("t6_nw", {96'b0, n_writes}, '0);
        drv(0, 1, 1, 32'h40, '0, '0, 0, 1);
        idle(1);
        @(negedge clk);
        chk("t6_keep", bus.r_data, w4);

        // random traffic over 16 words with aliased upper address bits
        for (int i = 0; i < 16; i++) drv(0, 1, 0, AW'(i * 16), '1, rnd_word(), 0, 1);
        for (int c = 0; c < 600; c++) begin
            a = ($urandom & 32'hFFFF_C00F) | AW'($urandom_range(0, 15) << 4);
            drv($urandom_range(0, 99) == 0, $urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a,
                BW'($urandom), rnd_word(), $urandom_range(0, 7) == 0, $urandom_range(0, 3) != 0);
        end
        repeat (4) idle(1);
        @(negedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
